sort3_unpermute: RTL and testbench
==================================

Name: sort3_unpermute

Overview:
- Decoder-side counterpart of the team's 3-input descending sorter.
- Accepts one sorted triple (no1 = max, no2 = mid, no3 = min) plus a 3-bit permutation code recording the original input order.
- Restores the original order (a, b, c) and emits it on a valid/ready stream.
- Two-stage registered pipeline (decode stage, output stage) with full backpressure and illegal-code handling; sits downstream of the sorter on the return path.

Parameters:
- WIDTH, 3, bit width of each data value.
- CNT_W, 8, width of the accepted-frame and dropped-frame counters.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  input frame valid.
- in_ready  out  1  block can accept a frame this cycle.
- no1  in  WIDTH  largest sorted value.
- no2  in  WIDTH  middle sorted value.
- no3  in  WIDTH  smallest sorted value.
- perm  in  3  permutation code, 0..5 legal.
- out_valid  out  1  restored frame valid.
- out_ready  in  1  downstream accepts frame.
- a  out  WIDTH  restored original value a.
- b  out  WIDTH  restored original value b.
- c  out  WIDTH  restored original value c.
- err_pulse  out  1  one-cycle pulse when a frame is dropped.
- frame_cnt  out  CNT_W  frames delivered on the output.
- drop_cnt  out  CNT_W  frames dropped.

Behaviour:
- Reset (rst asserted, asynchronous): all pipeline valids 0, a/b/c 0, out_valid 0, err_pulse 0, frame_cnt 0, drop_cnt 0. in_ready is 1 on the first clock after rst deasserts.
- Reset mid-operation discards in-flight frames without emitting them; counters clear.
- Permutation table: perm gives the source of (a, b, c) as sorted positions 1 = no1, 2 = no2, 3 = no3.
  - 0: (1,2,3)
  - 1: (1,3,2)
  - 2: (2,1,3)
  - 3: (2,3,1)
  - 4: (3,1,2)
  - 5: (3,2,1)
  - 6 and 7: illegal.
- Transfer rules: input transfer when in_valid && in_ready; output transfer when out_valid && out_ready.
- Stage 1 (S1): registers the decoded frame plus a legal flag on input transfer.
- Stage 2 (S2): output register. Its contents drive a/b/c/out_valid directly, with no combinational path from inputs to outputs.
- Ready propagation:
  - s2_ready = !out_valid || out_ready.
  - in_ready = !s1_valid || s1_advance, where s1_advance = s2_ready for a legal S1 frame and is always 1 for an illegal S1 frame.
- Latency: 2 cycles from input transfer to out_valid when unstalled. Throughput is 1 frame/cycle.
- Illegal frames are dropped at the S1 to S2 boundary. They never reach S2. In the cycle they leave S1, err_pulse = 1 and drop_cnt increments.
- a/b/c hold their value while out_valid && !out_ready. After an output transfer with no new frame, out_valid = 0 and a/b/c hold their last values.
- frame_cnt increments on each output transfer.
- Both counters wrap modulo 2^CNT_W (255 -> 0).
- Simultaneous S2 drain and S1 refill in the same cycle is legal and loses no frame.
- Input values are passed through unmodified. Equal values are allowed and are not errors.

Optional Feature:
- Macro: SORT3_ORDER_CHECK_EN.
- Compiled in:
  - S1 also checks no1 >= no2 >= no3 (unsigned).
  - An unordered frame is treated exactly as an illegal code: dropped, err_pulse, drop_cnt++.
  - An added output order_err (1 bit) is a sticky flag, set on the first unordered frame and cleared only by rst.
- Compiled out: no ordering check, no order_err port, unordered frames pass through.

Decomposition:
- Shared package sort3_pkg:
  - permutation code width constant.
  - PERM_MAX_LEGAL = 5.
  - Typedef for the source-select enum (SEL_NO1, SEL_NO2, SEL_NO3).
  - Function mapping perm to three selects; the verification model reuses it.
- One natural sub-module: sort3_perm_decode, combinational, maps perm to three selects plus legal. Instantiated in S1.

Test Plan:
- rst pulse mid-stream with S1/S2 full -> out_valid = 0 immediately, counters 0, no stale frame emitted after release.
- Sweep perm 0..5 with no1=6, no2=4, no3=1, out_ready=1 -> a/b/c = (6,4,1), (6,1,4), (4,6,1), (4,1,6), (1,6,4), (1,4,6), each 2 cycles after accept; frame_cnt = 6.
- perm=7 between two legal frames -> only the 2 legal frames appear; one err_pulse; drop_cnt = 1; frame_cnt = 2.
- out_ready held 0 for 5 cycles while 3 frames are offered -> in_ready drops after 2 accepts; a/b/c stable; release delivers all in order, none lost.
- 300 back-to-back legal frames, out_ready=1 -> one output per cycle; frame_cnt = 300 mod 256 = 44.
- With SORT3_ORDER_CHECK_EN: no1=2, no2=5, no3=1, perm=0 -> dropped, err_pulse, order_err = 1 and stays 1 through later legal frames until rst.

Source files
------------

// File: rtl/sort3_pkg.sv
// Shared types for the sort3 return path: source selects and the perm-code decode table.
package sort3_pkg;

  localparam int PERM_W = 3;
  localparam logic [PERM_W-1:0] PERM_MAX_LEGAL = 3'd5;

  typedef enum logic [1:0] {
    SEL_NO1 = 2'd0,
    SEL_NO2 = 2'd1,
    SEL_NO3 = 2'd2
  } sel_e;

  typedef struct packed {
    sel_e a;
    sel_e b;
    sel_e c;
  } sel_trio_t;

  // Illegal codes map to identity; callers gate on legality separately.
  function automatic sel_trio_t perm_to_sel(input logic [PERM_W-1:0] perm);
    sel_trio_t s;
    case (perm)
      3'd0:    s = '{a: SEL_NO1, b: SEL_NO2, c: SEL_NO3};
      3'd1:    s = '{a: SEL_NO1, b: SEL_NO3, c: SEL_NO2};
      3'd2:    s = '{a: SEL_NO2, b: SEL_NO1, c: SEL_NO3};
      3'd3:    s = '{a: SEL_NO2, b: SEL_NO3, c: SEL_NO1};
      3'd4:    s = '{a: SEL_NO3, b: SEL_NO1, c: SEL_NO2};
      3'd5:    s = '{a: SEL_NO3, b: SEL_NO2, c: SEL_NO1};
      default: s = '{a: SEL_NO1, b: SEL_NO2, c: SEL_NO3};
    endcase
    return s;
  endfunction

endpackage

// File: rtl/sort3_unpermute_if.sv
// Sorted-triple input stream and restored-triple output stream of sort3_unpermute.
interface sort3_unpermute_if #(parameter int WIDTH = 3);
  import sort3_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  no1;
  logic [WIDTH-1:0]  no2;
  logic [WIDTH-1:0]  no3;
  logic [PERM_W-1:0] perm;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  a;
  logic [WIDTH-1:0]  b;
  logic [WIDTH-1:0]  c;

  modport master (
    output in_valid, no1, no2, no3, perm, out_ready,
    input  in_ready, out_valid, a, b, c
  );

  modport slave (
    input  in_valid, no1, no2, no3, perm, out_ready,
    output in_ready, out_valid, a, b, c
  );

endinterface

// File: rtl/sort3_perm_decode.sv
// Combinational perm-code decoder: three source selects plus a legality flag.
module sort3_perm_decode
  import sort3_pkg::*;
(
  input  logic [PERM_W-1:0] perm,
  output sel_trio_t         sel,
  output logic              legal
);

  assign sel   = perm_to_sel(perm);
  assign legal = (perm <= PERM_MAX_LEGAL);

endmodule

// File: rtl/sort3_unpermute.sv
// Restores original (a,b,c) order from a sorted triple + perm code; 2-stage valid/ready pipe.
// Optional SORT3_ORDER_CHECK_EN: drop frames not sorted descending and raise sticky order_err.
module sort3_unpermute
  import sort3_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  sort3_unpermute_if.slave bus,
  output logic             err_pulse,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] drop_cnt
`ifdef SORT3_ORDER_CHECK_EN
  ,
  output logic             order_err
`endif
);

  sel_trio_t sel;
  logic      code_legal;

  sort3_perm_decode u_dec (
    .perm  (bus.perm),
    .sel   (sel),
    .legal (code_legal)
  );

  // Lane i of the restored triple picks from sorted[] by its select; index 0 is no1.
  logic [2:0][WIDTH-1:0] sorted;
  logic [2:0][WIDTH-1:0] restored;
  sel_e                  lane_sel [3];

  assign sorted      = {bus.no3, bus.no2, bus.no1};
  assign lane_sel[0] = sel.a;
  assign lane_sel[1] = sel.b;
  assign lane_sel[2] = sel.c;

  for (genvar i = 0; i < 3; i++) begin : g_lane
    assign restored[i] = sorted[lane_sel[i]];
  end

  logic unordered;
`ifdef SORT3_ORDER_CHECK_EN
  assign unordered = !((bus.no1 >= bus.no2) && (bus.no2 >= bus.no3));
`else
  assign unordered = 1'b0;
`endif

  logic frame_legal;
  assign frame_legal = code_legal && !unordered;

  logic                  s1_valid, s1_legal;
  logic [2:0][WIDTH-1:0] s1_data;
  logic                  s2_valid;
  logic [2:0][WIDTH-1:0] s2_data;

  logic s2_ready, s1_adv, s1_move, s1_drop;

  assign s2_ready = !s2_valid || bus.out_ready;
  // An illegal S1 frame never waits on S2: it is discarded on the next edge.
  assign s1_adv   = !s1_legal || s2_ready;
  assign s1_move  = s1_valid && s1_legal && s2_ready;
  assign s1_drop  = s1_valid && !s1_legal;

  assign bus.in_ready  = !s1_valid || s1_adv;
  assign bus.out_valid = s2_valid;
  assign bus.a         = s2_data[0];
  assign bus.b         = s2_data[1];
  assign bus.c         = s2_data[2];
  assign err_pulse     = s1_drop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_legal <= 1'b0;
      s1_data  <= '0;
      s2_valid <= 1'b0;
      s2_data  <= '0;
    end else begin
      if (bus.in_ready) begin
        s1_valid <= bus.in_valid;
        if (bus.in_valid) begin
          s1_legal <= frame_legal;
          s1_data  <= restored;
        end
      end
      if (s2_ready) begin
        s2_valid <= s1_move;
        if (s1_move) s2_data <= s1_data;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt <= '0;
      drop_cnt  <= '0;
    end else begin
      if (s2_valid && bus.out_ready) frame_cnt <= frame_cnt + 1'b1;
      if (s1_drop)                   drop_cnt  <= drop_cnt + 1'b1;
    end
  end

`ifdef SORT3_ORDER_CHECK_EN
  logic s1_unord;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_unord  <= 1'b0;
      order_err <= 1'b0;
    end else begin
      if (bus.in_ready && bus.in_valid) s1_unord <= unordered;
      if (s1_drop && s1_unord)          order_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_sort3_unpermute.sv
// Directed bench for sort3_unpermute: perm table sweep, backpressure, reset, wrap, order check.
module tb_sort3_unpermute;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic err_pulse;
  logic [7:0] frame_cnt, drop_cnt;
`ifdef SORT3_ORDER_CHECK_EN
  logic order_err;
  localparam bit ORD = 1'b1;
`else
  localparam bit ORD = 1'b0;
`endif

  sort3_unpermute_if #(.WIDTH(3)) bus();

  sort3_unpermute #(.WIDTH(3), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .err_pulse (err_pulse),
    .frame_cnt (frame_cnt),
    .drop_cnt  (drop_cnt)
`ifdef SORT3_ORDER_CHECK_EN
    ,
    .order_err (order_err)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Output transfers are observed on the falling edge before the edge that commits them.
  logic [8:0] q[$];
  always @(negedge clk)
    if (!rst && bus.out_valid && bus.out_ready) q.push_back({bus.a, bus.b, bus.c});

  typedef struct {
    logic [2:0] perm;
    logic [2:0] n1, n2, n3;
    logic [2:0] ea, eb, ec;
    bit         legal;
  } vec_t;

  vec_t tbl[11];

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] n1, input logic [2:0] n2, input logic [2:0] n3,
                       input logic [2:0] p);
    bus.in_valid = 1'b1;
    bus.no1 = n1; bus.no2 = n2; bus.no3 = n3; bus.perm = p;
  endtask

  int src[6][3] = '{'{0,1,2}, '{0,2,1}, '{1,0,2}, '{1,2,0}, '{2,0,1}, '{2,1,0}};

  initial begin
    int n_legal, n_illegal, stalls, bad;
    logic [2:0] v[3];
    logic [2:0] p;
    logic [8:0] e;

    tbl[0]  = '{3'd0, 3'd6, 3'd4, 3'd1, 3'd6, 3'd4, 3'd1, 1'b1};
    tbl[1]  = '{3'd1, 3'd6, 3'd4, 3'd1, 3'd6, 3'd1, 3'd4, 1'b1};
    tbl[2]  = '{3'd2, 3'd6, 3'd4, 3'd1, 3'd4, 3'd6, 3'd1, 1'b1};
    tbl[3]  = '{3'd3, 3'd6, 3'd4, 3'd1, 3'd4, 3'd1, 3'd6, 1'b1};
    tbl[4]  = '{3'd4, 3'd6, 3'd4, 3'd1, 3'd1, 3'd6, 3'd4, 1'b1};
    tbl[5]  = '{3'd5, 3'd6, 3'd4, 3'd1, 3'd1, 3'd4, 3'd6, 1'b1};
    tbl[6]  = '{3'd7, 3'd6, 3'd4, 3'd1, 3'd0, 3'd0, 3'd0, 1'b0};
    tbl[7]  = '{3'd2, 3'd5, 3'd5, 3'd5, 3'd5, 3'd5, 3'd5, 1'b1};
    tbl[8]  = '{3'd6, 3'd3, 3'd2, 3'd1, 3'd0, 3'd0, 3'd0, 1'b0};
    tbl[9]  = '{3'd0, 3'd2, 3'd5, 3'd1, 3'd2, 3'd5, 3'd1, !ORD};
    tbl[10] = '{3'd3, 3'd7, 3'd0, 3'd0, 3'd0, 3'd0, 3'd7, 1'b1};

    bus.in_valid = 1'b0; bus.no1 = '0; bus.no2 = '0; bus.no3 = '0; bus.perm = '0;
    bus.out_ready = 1'b1;

    // Reset state
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_err_pulse", err_pulse, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_drop_cnt", drop_cnt, 0);
    chk("rst_abc", {bus.a, bus.b, bus.c}, 0);
    cyc(); cyc();
    rst = 1'b0;
    cyc();
    chk("post_rst_in_ready", bus.in_ready, 1);

    // Table sweep: one frame at a time, output expected two edges after accept
    n_legal = 0; n_illegal = 0;
    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].n1, tbl[i].n2, tbl[i].n3, tbl[i].perm);
      chk($sformatf("t%0d_in_ready", i), bus.in_ready, 1);
      cyc();
      bus.in_valid = 1'b0;
      chk($sformatf("t%0d_err_pulse", i), err_pulse, !tbl[i].legal);
      cyc();
      chk($sformatf("t%0d_out_valid", i), bus.out_valid, tbl[i].legal);
      if (tbl[i].legal) begin
        chk($sformatf("t%0d_abc", i), {bus.a, bus.b, bus.c}, {tbl[i].ea, tbl[i].eb, tbl[i].ec});
        n_legal++;
      end else n_illegal++;
    end
    cyc();
    chk("tbl_frame_cnt", frame_cnt, n_legal);
    chk("tbl_drop_cnt", drop_cnt, n_illegal);
    chk("tbl_out_idle", bus.out_valid, 0);
    chk("tbl_abc_hold", {bus.a, bus.b, bus.c}, {3'd0, 3'd0, 3'd7});

    // Backpressure: 3 frames offered while output stalled
    q.delete();
    bus.out_ready = 1'b0;
    drive(3'd7, 3'd3, 3'd2, 3'd0);
    cyc();
    drive(3'd5, 3'd4, 3'd0, 3'd5);
    cyc();
    drive(3'd6, 3'd6, 3'd1, 3'd3);
    chk("bp_in_ready_low", bus.in_ready, 0);
    chk("bp_out_valid", bus.out_valid, 1);
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk($sformatf("bp_hold%0d_abc", k), {bus.a, bus.b, bus.c}, {3'd7, 3'd3, 3'd2});
      chk($sformatf("bp_hold%0d_in_ready", k), bus.in_ready, 0);
    end
    bus.out_ready = 1'b1;
    cyc();
    bus.in_valid = 1'b0;
    repeat (4) cyc();
    chk("bp_count", q.size(), 3);
    if (q.size() == 3) begin
      chk("bp_f0", q[0], {3'd7, 3'd3, 3'd2});
      chk("bp_f1", q[1], {3'd0, 3'd4, 3'd5});
      chk("bp_f2", q[2], {3'd6, 3'd1, 3'd6});
    end

    // Reset with both stages full
    q.delete();
    bus.out_ready = 1'b0;
    drive(3'd4, 3'd2, 3'd1, 3'd1);
    cyc();
    drive(3'd3, 3'd3, 3'd0, 3'd4);
    cyc();
    bus.in_valid = 1'b0;
    chk("mid_full_out_valid", bus.out_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", bus.out_valid, 0);
    chk("mid_rst_frame_cnt", frame_cnt, 0);
    chk("mid_rst_drop_cnt", drop_cnt, 0);
    cyc();
    rst = 1'b0;
    bus.out_ready = 1'b1;
    repeat (4) cyc();
    chk("mid_rst_no_stale", q.size(), 0);
    chk("mid_rst_idle", bus.out_valid, 0);

    // 300 back-to-back frames, counter wrap
    q.delete();
    stalls = 0;
    for (int i = 0; i < 300; i++) begin
      drive(3'd7, 3'((i % 5) + 2), 3'(i % 3), 3'(i % 6));
      if (!bus.in_ready) stalls++;
      cyc();
    end
    bus.in_valid = 1'b0;
    repeat (3) cyc();
    chk("b2b_stalls", stalls, 0);
    chk("b2b_frame_cnt", frame_cnt, 44);
    chk("b2b_drop_cnt", drop_cnt, 0);
    chk("b2b_count", q.size(), 300);
    bad = 0;
    if (q.size() == 300)
      for (int i = 0; i < 300; i++) begin
        v[0] = 3'd7; v[1] = 3'((i % 5) + 2); v[2] = 3'(i % 3);
        p = 3'(i % 6);
        e = {v[src[p][0]], v[src[p][1]], v[src[p][2]]};
        if (q[i] != e) bad++;
      end
    chk("b2b_data_mismatches", bad, 0);

`ifdef SORT3_ORDER_CHECK_EN
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("oc_rst_order_err", order_err, 0);
    drive(3'd2, 3'd5, 3'd1, 3'd0);
    cyc();
    bus.in_valid = 1'b0;
    chk("oc_err_pulse", err_pulse, 1);
    cyc();
    chk("oc_order_err", order_err, 1);
    chk("oc_drop_cnt", drop_cnt, 1);
    chk("oc_no_output", bus.out_valid, 0);
    drive(3'd6, 3'd4, 3'd1, 3'd0);
    cyc();
    bus.in_valid = 1'b0;
    cyc();
    chk("oc_legal_out", bus.out_valid, 1);
    cyc(); cyc();
    chk("oc_sticky", order_err, 1);
    rst = 1'b1;
    #1;
    chk("oc_cleared", order_err, 0);
    cyc();
    rst = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
